inst_fetch_unpack: RTL and testbench

- Fetch-side stage directly upstream of the instruction decoder.
- Accepts 64-bit instruction-memory response beats over a valid/ack handshake and splits each beat into two 32-bit instructions, low half first.
- Buffers the instructions in a small FIFO and presents them one per cycle with their PC under a valid/ready handshake.
- The decoder consumes the instruction word; the rest of the pipeline consumes the PC.

---
 rtl/inst_fetch_unpack.sv | 148 ++++++++++++++
 tb/tb_inst_fetch_unpack.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unpack.sv
// Instruction fetch unpacker: splits 64-bit memory beats into two 32-bit instructions,
// buffers them in a small FIFO and hands them to the decoder with their PC.
// Optional build macro INST_FETCH_HALT_ON_ZERO_EN stops fetch after an all-zero word is consumed.
module inst_fetch_unpack #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int PC_WIDTH       = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [PC_WIDTH-1:0]           start_pc,
    input  logic                          bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]     bus_resp,
    output logic                          bus_respack,
    input  logic                          flush,
    input  logic [PC_WIDTH-1:0]           flush_pc,
    output logic [BUS_DATA_WIDTH/2-1:0]   inst,
    output logic [PC_WIDTH-1:0]           inst_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          halted
);

    localparam int IW = BUS_DATA_WIDTH / 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [IW-1:0]   mem_r [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] inst_pc_r;
    logic            drop_low_r;

    logic            run_s;
    logic [CW-1:0]   free_s;
    logic            push_s;
    logic            pop_s;
    logic            halt_pop_s;
    logic [CW-1:0]   push_cnt_s;
    logic [CW-1:0]   pop_cnt_s;

    // Room is judged from the registered count only, so a pop never frees space in the same cycle.
    assign run_s       = (state_r == S_RUN);
    assign free_s      = CW'(FIFO_DEPTH) - count_r;
    assign bus_respack = run_s && (free_s >= CW'(2));
    assign inst_valid  = run_s && (count_r != {CW{1'b0}});
    assign inst        = mem_r[head_r];
    assign inst_pc     = inst_pc_r;
    assign fifo_count  = count_r;

    assign push_s     = bus_respcyc && bus_respack;
    assign pop_s      = inst_valid && inst_ready;
    assign push_cnt_s = push_s ? (drop_low_r ? CW'(1) : CW'(2)) : CW'(0);
    assign pop_cnt_s  = pop_s ? CW'(1) : CW'(0);

`ifdef INST_FETCH_HALT_ON_ZERO_EN
    assign halt_pop_s = pop_s && (mem_r[head_r] == {IW{1'b0}});
    assign halted     = (state_r == S_HALT);
`else
    assign halt_pop_s = 1'b0;
    assign halted     = 1'b0;
`endif

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (halt_pop_s) begin
                    state_s = S_HALT;
                end else begin
                    state_s = S_RUN;
                end
            end
            S_HALT: state_s = S_HALT;
            default: state_s = S_IDLE;
        endcase
        if (flush) begin
            state_s = S_RUN;
        end else begin
            state_s = state_s;
        end
    end

    // State register, FIFO storage, pointers, count and PC tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            count_r    <= {CW{1'b0}};
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            inst_pc_r  <= {PC_WIDTH{1'b0}};
            drop_low_r <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {IW{1'b0}};
            end
        end else begin
            state_r <= state_s;
            if (flush) begin
                count_r    <= {CW{1'b0}};
                head_r     <= {PW{1'b0}};
                tail_r     <= {PW{1'b0}};
                inst_pc_r  <= flush_pc;
                drop_low_r <= flush_pc[2];
            end else if ((state_r == S_IDLE) && start) begin
                inst_pc_r  <= start_pc;
                drop_low_r <= start_pc[2];
            end else begin
                if (pop_s) begin
                    head_r    <= head_r + PW'(1);
                    inst_pc_r <= inst_pc_r + PC_WIDTH'(4);
                end
                // A misaligned entry PC skips the low half of the first beat.
                if (push_s) begin
                    if (drop_low_r) begin
                        mem_r[tail_r] <= bus_resp[BUS_DATA_WIDTH-1:IW];
                        tail_r        <= tail_r + PW'(1);
                        drop_low_r    <= 1'b0;
                    end else begin
                        mem_r[tail_r]          <= bus_resp[IW-1:0];
                        mem_r[tail_r + PW'(1)] <= bus_resp[BUS_DATA_WIDTH-1:IW];
                        tail_r                 <= tail_r + PW'(2);
                    end
                end
                count_r <= count_r + push_cnt_s - pop_cnt_s;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unpack.sv
// Self-checking bench for inst_fetch_unpack: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_inst_fetch_unpack;

    localparam int D = 4;
`ifdef INST_FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] start_pc;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic        bus_respack;
    logic        flush;
    logic [63:0] flush_pc;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  fifo_count;
    logic        halted;

    int total = 0;
    int bad   = 0;

    // reference model
    int          m_state;
    logic [31:0] m_q[$];
    logic [63:0] m_pc;
    logic        m_drop;

    inst_fetch_unpack #(.BUS_DATA_WIDTH(64), .FIFO_DEPTH(D), .PC_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_respack(bus_respack),
        .flush(flush), .flush_pc(flush_pc), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .fifo_count(fifo_count),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_state = M_IDLE;
        m_q.delete();
        m_pc   = 64'd0;
        m_drop = 1'b0;
    endtask

    function automatic bit m_valid();
        return (m_state == M_RUN) && (m_q.size() != 0);
    endfunction

    function automatic bit m_ack();
        return (m_state == M_RUN) && ((D - m_q.size()) >= 2);
    endfunction

    task automatic check_model();
        chk("valid",   {63'd0, inst_valid},  {63'd0, m_valid()});
        chk("respack", {63'd0, bus_respack}, {63'd0, m_ack()});
        chk("count",   {61'd0, fifo_count},  64'(m_q.size()));
        chk("pc",      inst_pc,              m_pc);
        chk("halted",  {63'd0, halted},      {63'd0, (m_state == M_HALT)});
        if (m_valid()) chk("inst", {32'd0, inst}, {32'd0, m_q[0]});
    endtask

    // Check outputs, advance the model by one clock, then clock the DUT.
    task automatic step();
        bit v;
        bit a;
        logic [31:0] w;
        check_model();
        v = m_valid();
        a = m_ack();
        if (flush) begin
            m_q.delete();
            m_pc    = flush_pc;
            m_drop  = flush_pc[2];
            m_state = M_RUN;
        end else if (m_state == M_IDLE && start) begin
            m_state = M_RUN;
            m_pc    = start_pc;
            m_drop  = start_pc[2];
        end else if (m_state == M_RUN) begin
            if (v && inst_ready) begin
                w    = m_q.pop_front();
                m_pc = m_pc + 64'd4;
                if (HALT_EN && w == 32'd0) m_state = M_HALT;
            end
            if (a && bus_respcyc) begin
                if (!m_drop) m_q.push_back(bus_resp[31:0]);
                m_q.push_back(bus_resp[63:32]);
                m_drop = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges, released after one edge.
    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        model_clear();
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; start_pc = 64'd0; bus_respcyc = 1'b0;
        bus_resp = 64'd0; flush = 1'b0; flush_pc = 64'd0; inst_ready = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_count", {61'd0, fifo_count}, 64'd0);
        reset = 1'b1;
        bus_respcyc = 1'b1; bus_resp = 64'h1234_5678_9abc_def0;
        step();
        chk("idle_noack", {63'd0, bus_respack}, 64'd0);
        step();

        // start at 0x1000, one beat, two instructions out back to back
        bus_respcyc = 1'b0;
        start = 1'b1; start_pc = 64'h1000;
        step();
        start = 1'b0; inst_ready = 1'b1;
        bus_respcyc = 1'b1; bus_resp = 64'h00B50533_00A00093;
        step();
        bus_respcyc = 1'b0;
        chk("t1_inst0", {32'd0, inst}, 64'h00A00093);
        chk("t1_pc0", inst_pc, 64'h1000);
        step();
        chk("t1_inst1", {32'd0, inst}, 64'h00B50533);
        chk("t1_pc1", inst_pc, 64'h1004);
        step();
        chk("t1_empty", {61'd0, fifo_count}, 64'd0);

        // misaligned start: only the high half is kept
        async_reset();
        start = 1'b1; start_pc = 64'h1004;
        step();
        start = 1'b0;
        bus_respcyc = 1'b1; bus_resp = 64'h22222222_11111111;
        step();
        bus_respcyc = 1'b0;
        chk("t2_inst", {32'd0, inst}, 64'h22222222);
        chk("t2_pc", inst_pc, 64'h1004);
        step();
        chk("t2_empty", {63'd0, inst_valid}, 64'd0);

        // backpressure: two beats fill the FIFO, then drain with a beat pending
        inst_ready = 1'b0; bus_respcyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_resp = {$urandom, $urandom};
            step();
        end
        chk("t3_full", {61'd0, fifo_count}, 64'd4);
        chk("t3_noack", {63'd0, bus_respack}, 64'd0);
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        bus_respcyc = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // flush with three buffered entries and a same-cycle beat
        inst_ready = 1'b0;
        flush = 1'b1; flush_pc = 64'h1004;
        step();
        flush = 1'b0; bus_respcyc = 1'b1; bus_resp = 64'hAAAA0001_AAAA0000;
        step();
        bus_resp = 64'hBBBB0001_BBBB0000;
        step();
        chk("t4_three", {61'd0, fifo_count}, 64'd3);
        flush = 1'b1; flush_pc = 64'h2000; bus_resp = 64'hCCCC0001_CCCC0000;
        step();
        flush = 1'b0; bus_respcyc = 1'b0;
        chk("t4_count", {61'd0, fifo_count}, 64'd0);
        chk("t4_valid", {63'd0, inst_valid}, 64'd0);
        bus_respcyc = 1'b1; bus_resp = 64'hDDDD0001_DDDD0000;
        step();
        bus_respcyc = 1'b0;
        chk("t4_inst", {32'd0, inst}, 64'hDDDD0000);
        chk("t4_pc", inst_pc, 64'h2000);
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();

`ifdef INST_FETCH_HALT_ON_ZERO_EN
        // zero word halts fetch until a flush
        bus_respcyc = 1'b1; bus_resp = 64'h00000000_00000013;
        step();
        bus_respcyc = 1'b0;
        chk("t5_inst", {32'd0, inst}, 64'h13);
        step();
        step();
        chk("t5_halted", {63'd0, halted}, 64'd1);
        chk("t5_valid", {63'd0, inst_valid}, 64'd0);
        chk("t5_ack", {63'd0, bus_respack}, 64'd0);
        bus_respcyc = 1'b1; bus_resp = 64'h5555_5555_4444_4444;
        step();
        flush = 1'b1; flush_pc = 64'h3000;
        step();
        flush = 1'b0;
        chk("t5_unhalt", {63'd0, halted}, 64'd0);
        step();
        bus_respcyc = 1'b0;
        chk("t5_resume_pc", inst_pc, 64'h3000);
        for (int i = 0; i < 3; i++) step();
`endif

        // async reset with the FIFO half full
        inst_ready = 1'b0; bus_respcyc = 1'b1; bus_resp = 64'h7777_0001_7777_0000;
        step();
        bus_respcyc = 1'b0;
        chk("t6_half", {61'd0, fifo_count}, 64'd2);
        #2 reset = 1'b0;
        #1;
        model_clear();
        chk("t6_valid", {63'd0, inst_valid}, 64'd0);
        chk("t6_ack", {63'd0, bus_respack}, 64'd0);
        chk("t6_inst", {32'd0, inst}, 64'd0);
        chk("t6_count", {61'd0, fifo_count}, 64'd0);
        chk("t6_pc", inst_pc, 64'd0);
        chk("t6_halted", {63'd0, halted}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        bus_respcyc = 1'b1;
        step();
        step();
        chk("t6_idle_noack", {63'd0, bus_respack}, 64'd0);
        start = 1'b1; start_pc = 64'h4000;
        step();
        start = 1'b0;

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                async_reset();
                start = 1'b1; start_pc = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
                step();
            end
            flush       = ($urandom_range(0, 19) == 0);
            flush_pc    = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            start       = ($urandom_range(0, 29) == 0);
            start_pc    = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            bus_respcyc = ($urandom_range(0, 2) != 0);
            bus_resp    = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) bus_resp[31:0] = 32'd0;
            if ($urandom_range(0, 15) == 0) bus_resp[63:32] = 32'd0;
            inst_ready  = ($urandom_range(0, 3) != 0);
            step();
        end
        flush = 1'b0; start = 1'b0; bus_respcyc = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
